// File: rtl/otp_ctrl_chk_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otp_ctrl_chk_sched_pkg
// Description : Types and constants shared by the periodic check scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package otp_ctrl_chk_sched_pkg;

  localparam int ChkSchedMskW        = 32;
  localparam int ChkSchedStateW      = 10;
  localparam int DefaultCntWidth     = 40;
  localparam int DefaultReseedThresh = 255;
  localparam logic [DefaultCntWidth-1:0] DefaultLfsrSeed = 40'h1;
  // Galois taps for x^40 + x^38 + x^21 + x^19 + 1 (right-shifting form)
  localparam logic [DefaultCntWidth-1:0] DefaultLfsrPoly = 40'hA0_0014_0000;

  // Pairwise Hamming distance of 5 or more between all codes
  typedef enum logic [ChkSchedStateW-1:0] {
    ResetSt = 10'b1111100000,
    IdleSt  = 10'b0000011111,
    WaitSt  = 10'b1110000111,
    ErrorSt = 10'b0001111000
  } chk_sched_state_e;

  typedef enum logic [3:0] {
    On  = 4'b0101,
    Off = 4'b1010
  } lc_tx_t;

  function automatic logic lc_tx_test_true_loose(lc_tx_t val);
    return val != Off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/otp_ctrl_chk_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : otp_ctrl_chk_lfsr
// Description : Galois LFSR with draw counter and EDN reseed handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module otp_ctrl_chk_lfsr
  import otp_ctrl_chk_sched_pkg::*;
#(
  parameter int                  CntWidth     = DefaultCntWidth,
  parameter int                  EdnDw        = 64,
  parameter int                  ReseedThresh = DefaultReseedThresh,
  parameter logic [CntWidth-1:0] LfsrSeed     = CntWidth'(1),
  parameter logic [CntWidth-1:0] LfsrPoly     = CntWidth'(DefaultLfsrPoly)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                draw_i,
  output logic                edn_req_o,
  input  logic                edn_ack_i,
  input  logic [EdnDw-1:0]    edn_data_i,
  output logic [CntWidth-1:0] lfsr_o,
  output logic                zero_err_o
);

  localparam int RsW = $clog2(ReseedThresh + 1);

  logic [CntWidth-1:0] r_lfsr;
  logic [CntWidth-1:0] w_step;
  logic [RsW-1:0]      r_rs_cnt;
  logic                w_reseed;

  assign w_step     = (r_lfsr >> 1) ^ ({CntWidth{r_lfsr[0]}} & LfsrPoly);
  assign edn_req_o  = r_rs_cnt >= RsW'(ReseedThresh);
  assign w_reseed   = edn_req_o & edn_ack_i;
  assign lfsr_o     = r_lfsr;
  assign zero_err_o = r_lfsr == '0;

  // The draw count saturates at the threshold because it stops while a request is pending
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr   <= LfsrSeed;
      r_rs_cnt <= '0;
    end else if (w_reseed) begin
      r_lfsr   <= w_step ^ edn_data_i[CntWidth-1:0];
      r_rs_cnt <= '0;
    end else if (draw_i) begin
      r_lfsr <= w_step;
      if (!edn_req_o) r_rs_cnt <= r_rs_cnt + RsW'(1);
    end
  end

  generate
    if (EdnDw > CntWidth) begin : g_edn_unused
      logic unused_edn_hi;
      assign unused_edn_hi = ^edn_data_i[EdnDw-1:CntWidth];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/otp_ctrl_chk_sched.sv
`default_nettype none
// ============================================================================
// Module      : otp_ctrl_chk_sched
// Description : Round-robin scheduler for NumChk periodic/triggered partition
//               checks. Define OTP_CHK_SCHED_STATS_EN for per-channel counts.
// Revision    : 1.0 - initial release
// ============================================================================
module otp_ctrl_chk_sched
  import otp_ctrl_chk_sched_pkg::*;
#(
  parameter int                  NumChk       = 2,
  parameter int                  NumPart      = 10,
  parameter int                  CntWidth     = DefaultCntWidth,
  parameter int                  EdnDw        = 64,
  parameter int                  ReseedThresh = DefaultReseedThresh,
  parameter logic [CntWidth-1:0] LfsrSeed     = CntWidth'(1),
  parameter logic [CntWidth-1:0] LfsrPoly     = CntWidth'(DefaultLfsrPoly),
  localparam int                 ActW         = (NumChk > 1) ? $clog2(NumChk) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  output logic                             edn_req_o,
  input  logic                             edn_ack_i,
  input  logic [EdnDw-1:0]                 edn_data_i,
  input  logic                             timer_en_i,
  input  logic [NumChk-1:0]                trig_i,
  input  logic [NumChk-1:0]                pause_i,
  input  logic [31:0]                      timeout_i,
  input  logic [NumChk*ChkSchedMskW-1:0]   period_msk_i,
  output logic [NumChk*NumPart-1:0]        chk_req_o,
  input  logic [NumChk*NumPart-1:0]        chk_ack_i,
  output logic [ActW-1:0]                  active_o,
  output logic                             chk_pending_o,
  input  lc_tx_t                           escalate_en_i,
  output logic                             chk_timeout_o,
  output logic                             fsm_err_o
`ifdef OTP_CHK_SCHED_STATS_EN
  ,
  output logic [NumChk*16-1:0]             chk_done_cnt_o
`endif
);

  chk_sched_state_e        r_state;
  logic [ActW-1:0]         r_active, r_rr, w_grant_idx, w_rr_next;
  logic [NumPart-1:0]      r_req, w_ack_slice, w_req_next;
  logic [31:0]             r_tmo;
  logic [NumChk-1:0]       r_trig, w_expired, w_grant_oh;
  logic [CntWidth-1:0]     r_cnt [NumChk];
  logic [CntWidth-1:0]     w_lfsr, w_reload;
  logic [ChkSchedMskW-1:0] w_act_msk;
  logic                    r_timeout, r_fsm_err;
  logic                    w_grant_vld, w_tmo_hit, w_done, w_fatal, w_draw, w_lfsr_zero;

  otp_ctrl_chk_lfsr #(
    .CntWidth     (CntWidth),
    .EdnDw        (EdnDw),
    .ReseedThresh (ReseedThresh),
    .LfsrSeed     (LfsrSeed),
    .LfsrPoly     (LfsrPoly)
  ) u_lfsr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .draw_i     (w_draw),
    .edn_req_o  (edn_req_o),
    .edn_ack_i  (edn_ack_i),
    .edn_data_i (edn_data_i),
    .lfsr_o     (w_lfsr),
    .zero_err_o (w_lfsr_zero)
  );

  assign w_ack_slice = chk_ack_i[int'(r_active)*NumPart +: NumPart];
  assign w_req_next  = r_req & ~w_ack_slice;
  assign w_act_msk   = period_msk_i[int'(r_active)*ChkSchedMskW +: ChkSchedMskW];
  assign w_reload    = w_lfsr & {w_act_msk, {(CntWidth-ChkSchedMskW){1'b1}}};
  assign w_fatal     = lc_tx_test_true_loose(escalate_en_i) || w_lfsr_zero;
  // Timeout wins over a completion landing in the same cycle
  assign w_tmo_hit   = (timeout_i != '0) && (r_tmo == '0);
  assign w_done      = (r_state == WaitSt) && !w_tmo_hit && (w_req_next == '0) && !w_fatal;
  assign w_draw      = !w_fatal && (((r_state == ResetSt) && timer_en_i) || w_done);
  assign w_rr_next   = (int'(w_grant_idx) == NumChk - 1) ? '0 : w_grant_idx + 1'b1;

  always_comb begin
    for (int c = 0; c < NumChk; c++) begin
      w_expired[c] = ((period_msk_i[c*ChkSchedMskW +: ChkSchedMskW] != '0) && (r_cnt[c] == '0))
                     || r_trig[c];
    end
  end

  // First expired channel at or after the round-robin pointer, wrapping
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int i = 0; i < NumChk; i++) begin
      if (!w_grant_vld && w_expired[(int'(r_rr) + i) % NumChk]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = ActW'((int'(r_rr) + i) % NumChk);
      end
    end
    w_grant_oh = '0;
    if (w_grant_vld) w_grant_oh[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ResetSt;
      r_active  <= '0;
      r_rr      <= '0;
      r_req     <= '0;
      r_tmo     <= '0;
      r_trig    <= '0;
      r_timeout <= 1'b0;
      r_fsm_err <= 1'b0;
      for (int c = 0; c < NumChk; c++) r_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NumChk; c++) begin
        if ((r_state != ResetSt) && (r_cnt[c] != '0)) r_cnt[c] <= r_cnt[c] - 1'b1;
      end
      r_trig <= r_trig | trig_i;
      if (w_fatal) begin
        r_state   <= ErrorSt;
        r_fsm_err <= 1'b1;
        r_req     <= '0;
        r_trig    <= '0;
      end else begin
        case (r_state)
          ResetSt: if (timer_en_i) r_state <= IdleSt;
          IdleSt: begin
            if (w_grant_vld) begin
              r_state  <= WaitSt;
              r_active <= w_grant_idx;
              r_rr     <= w_rr_next;
              r_req    <= '1;
              r_tmo    <= timeout_i;
              r_trig   <= (r_trig & ~w_grant_oh) | trig_i;
            end
          end
          WaitSt: begin
            r_req <= w_req_next;
            if ((r_tmo != '0) && !pause_i[r_active]) r_tmo <= r_tmo - 1'b1;
            if (w_tmo_hit) begin
              r_state   <= ErrorSt;
              r_timeout <= 1'b1;
              r_req     <= '0;
              r_trig    <= '0;
            end else if (w_req_next == '0) begin
              r_state         <= IdleSt;
              r_cnt[r_active] <= w_reload;
            end
          end
          ErrorSt: begin
            r_req  <= '0;
            r_trig <= '0;
          end
          default: begin
            r_state   <= ErrorSt;
            r_fsm_err <= 1'b1;
            r_req     <= '0;
            r_trig    <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    chk_req_o = '0;
    if (r_state == WaitSt) chk_req_o[int'(r_active)*NumPart +: NumPart] = r_req;
  end

  assign active_o      = r_active;
  assign chk_pending_o = (|r_trig) || (r_state == WaitSt);
  assign chk_timeout_o = r_timeout;
  assign fsm_err_o     = r_fsm_err;

`ifdef OTP_CHK_SCHED_STATS_EN
  logic [15:0] r_done_cnt [NumChk];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChk; c++) r_done_cnt[c] <= '0;
    end else if (w_done && (r_done_cnt[r_active] != 16'hFFFF)) begin
      r_done_cnt[r_active] <= r_done_cnt[r_active] + 16'd1;
    end
  end

  for (genvar c = 0; c < NumChk; c++) begin : g_done_out
    assign chk_done_cnt_o[c*16 +: 16] = r_done_cnt[c];
  end
`endif

endmodule
`default_nettype wire
